// File: rtl/ISO14443A_pkg.sv
// Shared ISO14443A types: rx frame status codes, controller states and CRC_A seed.
package ISO14443A_pkg;

  typedef enum logic [2:0] {
    RxFrameStatus_NONE     = 3'd0,
    RxFrameStatus_OK       = 3'd1,
    RxFrameStatus_EMPTY    = 3'd2,
    RxFrameStatus_PARITY   = 3'd3,
    RxFrameStatus_SEQUENCE = 3'd4,
    RxFrameStatus_OVERFLOW = 3'd5,
    RxFrameStatus_ABORTED  = 3'd6,
    RxFrameStatus_CRC      = 3'd7
  } RxFrameStatus;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HOLD    = 2'd3
  } rx_frame_state_e;

  localparam logic [15:0] CRC_A_INIT = 16'h6363;

endpackage

// File: rtl/crc_a_byte.sv
// Combinational single-byte CRC_A update (reflected poly 0x8408), shared by rx and tx paths.
module crc_a_byte (
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Single-frame buffer/classifier between rx and the PICC layer, streamed out over valid/ready.
// Optional CRC_A residue check enabled by defining RX_FRAME_CTRL_CRC_CHECK_EN.
module rx_frame_ctrl
  import ISO14443A_pkg::*;
#(
  parameter int MAX_BYTES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tx_busy,
  input  logic                             soc,
  input  logic                             eoc,
  input  logic                             data_valid,
  input  logic                             sequence_error,
  input  logic                             parity_error,
  input  logic [7:0]                       data,
  input  logic [2:0]                       data_bits,
  output logic                             frame_valid,
  output RxFrameStatus                     frame_status,
  output logic [$clog2(MAX_BYTES+1)-1:0]   frame_len,
  output logic [2:0]                       frame_last_bits,
  output logic [7:0]                       out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             overrun
);

  localparam int PW = $clog2(MAX_BYTES + 1);
  localparam int AW = $clog2(MAX_BYTES);

  rx_frame_state_e state_q, state_d;
  RxFrameStatus    status_q, status_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   len_q, len_d;
  logic [2:0]      last_bits_q, last_bits_d;
  logic            overrun_q, overrun_d;
  logic            we;
  logic            full;
  logic            at_last;
  logic [7:0]      mem_q [MAX_BYTES];

`ifdef RX_FRAME_CTRL_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d, crc_nx;

  crc_a_byte u_crc (
    .crc_in  (crc_q),
    .byte_in (data),
    .crc_out (crc_nx)
  );
`endif

  assign full    = (wptr_q == PW'(MAX_BYTES));
  assign at_last = (rptr_q == len_q - PW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      status_q    <= RxFrameStatus_NONE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      len_q       <= '0;
      last_bits_q <= '0;
      overrun_q   <= 1'b0;
`ifdef RX_FRAME_CTRL_CRC_CHECK_EN
      crc_q       <= CRC_A_INIT;
`endif
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      len_q       <= len_d;
      last_bits_q <= last_bits_d;
      overrun_q   <= overrun_d;
`ifdef RX_FRAME_CTRL_CRC_CHECK_EN
      crc_q       <= crc_d;
`endif
    end
  end

  // Frame storage is data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[wptr_q[AW-1:0]] <= data;
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    len_d       = len_q;
    last_bits_d = last_bits_q;
    overrun_d   = 1'b0;
    we          = 1'b0;
`ifdef RX_FRAME_CTRL_CRC_CHECK_EN
    crc_d       = crc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (soc && !tx_busy) begin
          state_d  = ST_RECV;
          status_d = RxFrameStatus_NONE;
          wptr_d   = '0;
`ifdef RX_FRAME_CTRL_CRC_CHECK_EN
          crc_d    = CRC_A_INIT;
`endif
        end
      end
      ST_RECV: begin
        if (tx_busy) begin
          status_d = RxFrameStatus_ABORTED;
          state_d  = ST_DISCARD;
        end else if (sequence_error) begin
          status_d = RxFrameStatus_SEQUENCE;
          state_d  = ST_DISCARD;
        end else if (parity_error) begin
          status_d = RxFrameStatus_PARITY;
          state_d  = ST_DISCARD;
        end else if (data_valid) begin
          if (full) begin
            status_d = RxFrameStatus_OVERFLOW;
            state_d  = ST_DISCARD;
          end else begin
            we     = 1'b1;
            wptr_d = wptr_q + PW'(1);
`ifdef RX_FRAME_CTRL_CRC_CHECK_EN
            crc_d  = crc_nx;
`endif
          end
        end else if (eoc) begin
          if (data_bits != 3'd0) begin
            if (full) begin
              status_d = RxFrameStatus_OVERFLOW;
              state_d  = ST_DISCARD;
            end else begin
              we          = 1'b1;
              wptr_d      = wptr_q + PW'(1);
              len_d       = wptr_q + PW'(1);
              last_bits_d = data_bits;
              rptr_d      = '0;
              status_d    = RxFrameStatus_OK;
              state_d     = ST_HOLD;
            end
          end else if (wptr_q == '0) begin
            status_d = RxFrameStatus_EMPTY;
            state_d  = ST_IDLE;
`ifdef RX_FRAME_CTRL_CRC_CHECK_EN
          end else if (wptr_q >= PW'(3) && crc_q != 16'h0000) begin
            status_d = RxFrameStatus_CRC;
            state_d  = ST_DISCARD;
`endif
          end else begin
            len_d       = wptr_q;
            last_bits_d = 3'd0;
            rptr_d      = '0;
            status_d    = RxFrameStatus_OK;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_DISCARD: begin
        if (eoc) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        // A second frame cannot be buffered; flag it and keep the held one intact.
        if (soc && !tx_busy) overrun_d = 1'b1;
        if (out_ready) begin
          rptr_d = rptr_q + PW'(1);
          if (at_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_valid     = (state_q == ST_HOLD);
    out_valid       = (state_q == ST_HOLD);
    out_data        = out_valid ? mem_q[rptr_q[AW-1:0]] : 8'h00;
    out_last        = out_valid && at_last;
    frame_status    = status_q;
    frame_len       = len_q;
    frame_last_bits = last_bits_q;
    overrun         = overrun_q;
  end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Frame-level controller between `rx` and the PICC protocol layer. It consumes the `rx` event stream (soc/eoc/data/errors), buffers one frame of up to `MAX_BYTES` bytes, and classifies the frame as good or errored. It releases the frame to the consumer over a valid/ready byte stream and ignores receiver activity while the transmitter is busy. Only one frame is held at a time; the controller defines the ownership of that frame between `rx` and the upper layer.

## Interface
- `MAX_BYTES`, 16: buffer depth in bytes, ≥ 2; frames longer than this are errored.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `tx_busy`  in  1  transmitter active; rx events are ignored while high.
- `soc`, `eoc`, `data_valid`, `sequence_error`, `parity_error`  in  1 each  event strobes from `rx`, one cycle wide
- `data`  in  8  byte from `rx`, LSB first on air
- `data_bits`  in  3  valid bits of a partial byte presented with `eoc` (0 = whole bytes only)
- `frame_valid`  out  1  a frame is held and ready to stream
- `frame_status`  out  `RxFrameStatus`  status of the held or last frame
- `frame_len`  out  $clog2(MAX_BYTES+1)  bytes in the held frame, including a partial byte
- `frame_last_bits`  out  3  valid bits in the final byte (0 = full)
- `out_data`  out  8  current byte
- `out_valid`  out  1  byte available
- `out_ready`  in  1  consumer accepts byte
- `out_last`  out  1  current byte is the frame's final byte
- `overrun`  out  1  one-cycle pulse: soc arrived while a frame was held, and that new frame was dropped

## Operation
- Reset values: all outputs 0; `frame_status` = `RxFrameStatus_NONE`; state IDLE; write and read pointers 0.
- States:
  - IDLE: `soc` && !`tx_busy` → RECV, with the write pointer cleared.
  - RECV:
    - `data_valid` stores `data` at the write pointer, then increments the pointer.
    - A store when pointer == `MAX_BYTES` sets the status to OVERFLOW → DISCARD.
    - `sequence_error` → status SEQUENCE → DISCARD.
    - `parity_error` → status PARITY → DISCARD.
    - `eoc` completes the frame: if `data_bits` != 0, store `data` as a partial byte (same overflow rule) and latch `frame_last_bits`=`data_bits`.
    - At `eoc`, a frame of 0 bytes is status EMPTY and returns to IDLE with `frame_valid` low.
    - At `eoc`, a non-empty frame is status OK → HOLD.
  - DISCARD: wait for `eoc` → IDLE. `frame_valid` stays low; `frame_status` keeps the error code until the next `soc`.
  - HOLD: `frame_valid`=1 and `out_valid`=1. `out_data` = buffer[read pointer].
    - A transfer (`out_valid`&&`out_ready`) increments the read pointer.
    - The transfer on which `out_last` is high → IDLE, with `frame_valid` and `out_valid` cleared on the next cycle.
    - `soc` in HOLD pulses `overrun`; all rx events up to and including the matching `eoc` are dropped. The held frame is unaffected.
- `tx_busy` gating:
  - `tx_busy` is sampled with each event.
  - `soc` seen while `tx_busy` high is ignored, and so is the rest of that frame up to its `eoc`.
  - `tx_busy` rising during RECV → status ABORTED → DISCARD.
- Event priority in one cycle: error > `data_valid` > `eoc`. `soc` coincident with `eoc` in IDLE is impossible from `rx` and needs no handling.

## Timing
- `frame_valid`, `out_valid` and `frame_len` rise the cycle after `eoc` is sampled in RECV.
- `out_data` is combinational from the buffer. First byte is available on that cycle; sustained rate is one byte per cycle.
- `out_last` = `out_valid` && (read pointer == `frame_len`-1).
- `frame_status` updates the cycle after the event that decides it.
- `overrun` is registered and high one cycle after the offending `soc`.
- Asynchronous reset mid-frame or mid-stream returns to IDLE immediately. Buffer contents are not cleared.

## Configuration
- `RX_FRAME_CTRL_CRC_CHECK_EN` defined:
  - A CRC_A (init 0x6363, reflected polynomial 0x8408, no final XOR) runs over every stored full byte.
  - At `eoc` with a full-byte frame of ≥ 3 bytes, a nonzero residue gives status CRC → DISCARD.
  - Frames of 1–2 bytes, or ending in a partial byte, skip the check.
- Undefined: no CRC logic and status CRC is never produced.

## Structure
- `ISO14443A_pkg` gains `RxFrameStatus` enum: `RxFrameStatus_NONE`, `_OK`, `_EMPTY`, `_PARITY`, `_SEQUENCE`, `_OVERFLOW`, `_ABORTED`, `_CRC`.
- `ISO14443A_pkg` also gains the constant `CRC_A_INIT` = 16'h6363.
- One sub-module, `crc_a_byte`: a combinational single-byte CRC_A update (crc_in, byte → crc_out), reused later by the tx path.

## Test plan
- Good frame: send 0x26 as 7 bits → `frame_valid`, `frame_len`=1, `frame_last_bits`=7, status OK. One transfer shows `out_data`=0x26 with `out_last` high.
- Parity error: bytes 0x93,0x20 with the parity of byte 1 flipped → `frame_valid` never rises, status PARITY, next `soc` accepted normally.
- Overflow: `MAX_BYTES`=4 with 5 bytes sent → status OVERFLOW, no `frame_valid`.
- Overrun: hold a 2-byte frame with `out_ready`=0 and send another frame → `overrun` pulses once. Then stream with `out_ready`=1 → original bytes out, back-to-back.
- Gating: `tx_busy` high during a full frame → no state change. `tx_busy` rising mid-frame → status ABORTED.
- CRC (macro on): 0x50,0x00,0x57,0xCD → OK; corrupt 0xCD to 0xCC → CRC.
